// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: FSM state encoding, RV32I funct3 codes
// and the raw-word load select presented to data memory.
package lsu_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ACC1 = 3'd1;
    localparam logic [2:0] ST_ACC2 = 3'd2;
    localparam logic [2:0] ST_CAP  = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [2:0] DMEM_LS_WORD = 3'b010;

    // Stores only have SB/SH/SW; loads lack 011 and the unsigned-word codes.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        if (we)
            return f3 > F3_W;
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte-enables/data shifted over an 8-byte window,
// load data merged from two words, shifted down and sign/zero extended.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword0,
    input  logic [31:0] i_rword1,
    output logic [7:0]  o_be,
    output logic [63:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [3:0]  w_be_base;
    logic [31:0] w_wdata_base;
    logic [31:0] w_rshift;

    always_comb begin
        w_be_base    = 4'b1111;
        w_wdata_base = i_wdata;
        case (i_funct3[1:0])
            2'b00: begin
                w_be_base    = 4'b0001;
                w_wdata_base = {24'd0, i_wdata[7:0]};
            end
            2'b01: begin
                w_be_base    = 4'b0011;
                w_wdata_base = {16'd0, i_wdata[15:0]};
            end
            default: ;
        endcase
    end

    // Upper half of the window belongs to the following word when an access is split.
    assign o_be    = {4'b0000, w_be_base} << i_off;
    assign o_wdata = {32'd0, w_wdata_base} << {i_off, 3'b000};

    assign w_rshift = 32'({i_rword1, i_rword0} >> {i_off, 3'b000});

    always_comb begin
        o_rdata = w_rshift;
        case (i_funct3)
            F3_B:    o_rdata = {{24{w_rshift[7]}}, w_rshift[7:0]};
            F3_BU:   o_rdata = {24'd0, w_rshift[7:0]};
            F3_H:    o_rdata = {{16{w_rshift[15]}}, w_rshift[15:0]};
            F3_HU:   o_rdata = {16'd0, w_rshift[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: store 2 cycles, load 3, split access +1 (MISALIGN_SPLIT_EN enables
// word-crossing splits; otherwise misalignment faults). Single outstanding request, ready only in IDLE.
module lsu_ctrl
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        dmem_rd,
    output logic [3:0]  dmem_we,
    output logic [2:0]  dmem_load_select,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata
);

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic        r_we;
    logic        r_split;
    logic        r_fault;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_word0;
    logic [31:0] r_word1;
    logic        w_accept;
    logic        w_illegal;
    logic        w_fault;
    logic        w_split;
    logic [7:0]  w_be;
    logic [63:0] w_wdata;
    logic [31:0] w_rdata;

    assign w_accept  = req_valid && req_ready;
    assign w_illegal = f3_illegal(req_we, req_funct3);

`ifdef MISALIGN_SPLIT_EN
    logic w_cross;
    assign w_cross = ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)) ||
                     ((req_funct3[1:0] == 2'b01) && (req_addr[1:0] == 2'b11));
    assign w_fault = w_illegal;
    assign w_split = w_cross && !w_illegal;
`else
    logic w_misalign;
    assign w_misalign = ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)) ||
                        ((req_funct3[1:0] == 2'b01) && req_addr[0]);
    assign w_fault = w_illegal || w_misalign;
    assign w_split = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = w_fault ? ST_RESP : ST_ACC1;
            ST_ACC1: w_next = r_split ? ST_ACC2 : (r_we ? ST_RESP : ST_CAP);
            ST_ACC2: w_next = r_we ? ST_RESP : ST_CAP;
            ST_CAP:  w_next = ST_RESP;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= ST_IDLE;
            r_we     <= 1'b0;
            r_split  <= 1'b0;
            r_fault  <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_word0  <= 32'd0;
            r_word1  <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_we     <= req_we;
                r_split  <= w_split;
                r_fault  <= w_fault;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_word0  <= 32'd0;
                r_word1  <= 32'd0;
            end
            // Memory returns data one cycle after each read, so the low word lands in ACC2 when split.
            if ((r_state == ST_ACC2) || ((r_state == ST_CAP) && !r_split))
                r_word0 <= dmem_rdata;
            if ((r_state == ST_CAP) && r_split)
                r_word1 <= dmem_rdata;
        end
    end

    lsu_align u_align (
        .i_funct3 (r_funct3),
        .i_off    (r_addr[1:0]),
        .i_wdata  (r_wdata),
        .i_rword0 (r_word0),
        .i_rword1 (r_word1),
        .o_be     (w_be),
        .o_wdata  (w_wdata),
        .o_rdata  (w_rdata)
    );

    assign req_ready        = (r_state == ST_IDLE);
    assign dmem_rd          = (r_state == ST_ACC1) || (r_state == ST_ACC2);
    assign dmem_we          = (!rstn || !r_we)        ? 4'b0000   :
                              (r_state == ST_ACC1)    ? w_be[3:0] :
                              (r_state == ST_ACC2)    ? w_be[7:4] : 4'b0000;
    assign dmem_load_select = DMEM_LS_WORD;
    assign dmem_addr        = {r_addr[31:2], 2'b00} + ((r_state == ST_ACC2) ? 32'd4 : 32'd0);
    assign dmem_wdata       = (r_state == ST_ACC2) ? w_wdata[63:32] : w_wdata[31:0];

    assign resp_valid = (r_state == ST_RESP);
    assign resp_fault = resp_valid && r_fault;
    assign resp_rdata = (resp_valid && !r_fault && !r_we) ? w_rdata : 32'd0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: vector table for single requests plus hand sequences
// for busy-time request changes and mid-operation reset; a byte-lane memory model serves dmem.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        dmem_rd;
    logic [3:0]  dmem_we;
    logic [2:0]  dmem_load_select;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;

    lsu_ctrl dut (
        .clk              (clk),
        .rstn             (rstn),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_we           (req_we),
        .req_funct3       (req_funct3),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_fault       (resp_fault),
        .dmem_rd          (dmem_rd),
        .dmem_we          (dmem_we),
        .dmem_load_select (dmem_load_select),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_rdata       (dmem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:15];

    always @(posedge clk) begin
        if (dmem_rd) begin
            dmem_rdata <= mem[dmem_addr[5:2]];
            for (int i = 0; i < 4; i++)
                if (dmem_we[i]) mem[dmem_addr[5:2]][8*i +: 8] <= dmem_wdata[8*i +: 8];
        end
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        fault;
        logic [31:0] rdata;
        int          lat;
        int          nacc;
        logic [31:0] a0_addr;
        logic [3:0]  a0_we;
        logic [31:0] a0_wdata;
        logic [31:0] a1_addr;
        logic [3:0]  a1_we;
        logic [31:0] a1_wdata;
    } vec_t;

    vec_t vt[$];

    int n_checks = 0;
    int n_fail   = 0;

    int          got_lat;
    logic        got_fault;
    logic [31:0] got_rdata;
    logic [31:0] q_addr[$];
    logic [3:0]  q_we[$];
    logic [31:0] q_wdata[$];

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic fault, input logic [31:0] rdata,
                                input int lat, input int nacc,
                                input logic [31:0] a0a, input logic [3:0] a0w, input logic [31:0] a0d,
                                input logic [31:0] a1a, input logic [3:0] a1w, input logic [31:0] a1d);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.fault = fault; v.rdata = rdata; v.lat = lat; v.nacc = nacc;
        v.a0_addr = a0a; v.a0_we = a0w; v.a0_wdata = a0d;
        v.a1_addr = a1a; v.a1_we = a1w; v.a1_wdata = a1d;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request and follow it to its response, logging every dmem access.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        int cyc;
        q_addr.delete();
        q_we.delete();
        q_wdata.delete();
        @(negedge clk);
        check("ready before request", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        while (!resp_valid && cyc < 10) begin
            if (dmem_rd) begin
                q_addr.push_back(dmem_addr);
                q_we.push_back(dmem_we);
                q_wdata.push_back(dmem_wdata);
            end
            @(negedge clk);
            cyc++;
        end
        got_lat   = resp_valid ? cyc : -1;
        got_fault = resp_fault;
        got_rdata = resp_rdata;
    endtask

    initial begin
        // SB/SW fill, natural loads, illegal funct3
        vt.push_back(mk(1, 3'b000, 32'h40000001, 32'h000000AB, 0, 32'h0, 2, 1, 32'h40000000, 4'b0010, 32'h0000AB00, 32'h0, 4'h0, 32'h0));
        vt.push_back(mk(1, 3'b010, 32'h40000000, 32'h80FF7F01, 0, 32'h0, 2, 1, 32'h40000000, 4'b1111, 32'h80FF7F01, 32'h0, 4'h0, 32'h0));
        vt.push_back(mk(1, 3'b010, 32'h40000004, 32'h00000000, 0, 32'h0, 2, 1, 32'h40000004, 4'b1111, 32'h00000000, 32'h0, 4'h0, 32'h0));
        vt.push_back(mk(1, 3'b010, 32'h40000008, 32'h00000000, 0, 32'h0, 2, 1, 32'h40000008, 4'b1111, 32'h00000000, 32'h0, 4'h0, 32'h0));
        vt.push_back(mk(0, 3'b000, 32'h40000003, 32'h0, 0, 32'hFFFFFF80, 3, 1, 32'h40000000, 4'b0000, 32'h0, 32'h0, 4'h0, 32'h0));
        vt.push_back(mk(0, 3'b100, 32'h40000003, 32'h0, 0, 32'h00000080, 3, 1, 32'h40000000, 4'b0000, 32'h0, 32'h0, 4'h0, 32'h0));
        vt.push_back(mk(0, 3'b001, 32'h40000000, 32'h0, 0, 32'h00007F01, 3, 1, 32'h40000000, 4'b0000, 32'h0, 32'h0, 4'h0, 32'h0));
        vt.push_back(mk(0, 3'b101, 32'h40000002, 32'h0, 0, 32'h000080FF, 3, 1, 32'h40000000, 4'b0000, 32'h0, 32'h0, 4'h0, 32'h0));
        vt.push_back(mk(0, 3'b001, 32'h40000002, 32'h0, 0, 32'hFFFF80FF, 3, 1, 32'h40000000, 4'b0000, 32'h0, 32'h0, 4'h0, 32'h0));
        vt.push_back(mk(0, 3'b010, 32'h40000000, 32'h0, 0, 32'h80FF7F01, 3, 1, 32'h40000000, 4'b0000, 32'h0, 32'h0, 4'h0, 32'h0));
        vt.push_back(mk(0, 3'b000, 32'h40000001, 32'h0, 0, 32'h0000007F, 3, 1, 32'h40000000, 4'b0000, 32'h0, 32'h0, 4'h0, 32'h0));
        vt.push_back(mk(1, 3'b001, 32'h40000012, 32'h1234BEEF, 0, 32'h0, 2, 1, 32'h40000010, 4'b1100, 32'hBEEF0000, 32'h0, 4'h0, 32'h0));
        vt.push_back(mk(0, 3'b001, 32'h40000012, 32'h0, 0, 32'hFFFFBEEF, 3, 1, 32'h40000010, 4'b0000, 32'h0, 32'h0, 4'h0, 32'h0));
        vt.push_back(mk(0, 3'b111, 32'h40000000, 32'h0, 1, 32'h0, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0));
        vt.push_back(mk(0, 3'b011, 32'h40000000, 32'h0, 1, 32'h0, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0));
        vt.push_back(mk(0, 3'b110, 32'h40000000, 32'h0, 1, 32'h0, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0));
        vt.push_back(mk(1, 3'b011, 32'h40000000, 32'h5, 1, 32'h0, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0));
        vt.push_back(mk(1, 3'b100, 32'h40000000, 32'h5, 1, 32'h0, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0));
`ifdef MISALIGN_SPLIT_EN
        vt.push_back(mk(1, 3'b010, 32'h40000006, 32'h11223344, 0, 32'h0, 3, 2, 32'h40000004, 4'b1100, 32'h33440000, 32'h40000008, 4'b0011, 32'h00001122));
        vt.push_back(mk(0, 3'b010, 32'h40000006, 32'h0, 0, 32'h11223344, 4, 2, 32'h40000004, 4'b0000, 32'h0, 32'h40000008, 4'b0000, 32'h0));
        vt.push_back(mk(0, 3'b001, 32'h40000005, 32'h0, 0, 32'h00004400, 3, 1, 32'h40000004, 4'b0000, 32'h0, 32'h0, 4'h0, 32'h0));
        vt.push_back(mk(1, 3'b001, 32'h40000007, 32'h00005566, 0, 32'h0, 3, 2, 32'h40000004, 4'b1000, 32'h66000000, 32'h40000008, 4'b0001, 32'h00000055));
        vt.push_back(mk(0, 3'b101, 32'h40000007, 32'h0, 0, 32'h00005566, 4, 2, 32'h40000004, 4'b0000, 32'h0, 32'h40000008, 4'b0000, 32'h0));
        vt.push_back(mk(1, 3'b001, 32'h40000005, 32'h00007788, 0, 32'h0, 2, 1, 32'h40000004, 4'b0110, 32'h00778800, 32'h0, 4'h0, 32'h0));
`else
        vt.push_back(mk(1, 3'b010, 32'h40000006, 32'h11223344, 1, 32'h0, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0));
        vt.push_back(mk(0, 3'b010, 32'h40000006, 32'h0, 1, 32'h0, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0));
        vt.push_back(mk(0, 3'b001, 32'h40000005, 32'h0, 1, 32'h0, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0));
        vt.push_back(mk(1, 3'b001, 32'h40000007, 32'h00005566, 1, 32'h0, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0));
        vt.push_back(mk(0, 3'b101, 32'h40000007, 32'h0, 1, 32'h0, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0));
        vt.push_back(mk(1, 3'b001, 32'h40000005, 32'h00007788, 1, 32'h0, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0));
`endif

        repeat (3) @(negedge clk);
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset resp_fault", 32'(resp_fault), 32'd0);
        check("reset resp_rdata", resp_rdata, 32'd0);
        check("reset dmem_rd", 32'(dmem_rd), 32'd0);
        check("reset dmem_we", 32'(dmem_we), 32'd0);
        check("load_select", 32'(dmem_load_select), 32'd2);
        rstn = 1'b1;

        foreach (vt[i]) begin
            issue(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata);
            check($sformatf("v%0d latency", i), 32'(got_lat), 32'(vt[i].lat));
            check($sformatf("v%0d fault", i), 32'(got_fault), 32'(vt[i].fault));
            check($sformatf("v%0d rdata", i), got_rdata, vt[i].rdata);
            check($sformatf("v%0d accesses", i), 32'(q_addr.size()), 32'(vt[i].nacc));
            if (q_addr.size() > 0 && vt[i].nacc > 0) begin
                check($sformatf("v%0d acc1 addr", i), q_addr[0], vt[i].a0_addr);
                check($sformatf("v%0d acc1 we", i), 32'(q_we[0]), 32'(vt[i].a0_we));
                if (vt[i].we) check($sformatf("v%0d acc1 wdata", i), q_wdata[0], vt[i].a0_wdata);
            end
            if (q_addr.size() > 1 && vt[i].nacc > 1) begin
                check($sformatf("v%0d acc2 addr", i), q_addr[1], vt[i].a1_addr);
                check($sformatf("v%0d acc2 we", i), 32'(q_we[1]), 32'(vt[i].a1_we));
                if (vt[i].we) check($sformatf("v%0d acc2 wdata", i), q_wdata[1], vt[i].a1_wdata);
            end
        end

        // Request fields change while busy: must be ignored, no write may appear.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40000000; req_wdata = 32'h0;
        @(negedge clk);
        req_we = 1'b1; req_wdata = 32'hDEADBEEF;
        check("busy ready", 32'(req_ready), 32'd0);
        check("busy acc1 we", 32'(dmem_we), 32'd0);
        @(negedge clk);
        check("busy cap we", 32'(dmem_we), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        check("busy resp_valid", 32'(resp_valid), 32'd1);
        check("busy resp_rdata", resp_rdata, 32'h80FF7F01);
        issue(1'b0, 3'b010, 32'h40000000, 32'h0);
        check("busy readback", got_rdata, 32'h80FF7F01);

        // Reset during the access cycle of an aligned store.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40000000; req_wdata = 32'h12345678;
        @(negedge clk);
        req_valid = 1'b0;
        check("abort acc1 we armed", 32'(dmem_we), 32'hF);
        rstn = 1'b0;
        #1;
        check("abort acc1 we gated", 32'(dmem_we), 32'd0);
        @(negedge clk);
        check("abort idle", 32'(req_ready), 32'd1);
        check("abort no resp", 32'(resp_valid), 32'd0);
        rstn = 1'b1;
        issue(1'b0, 3'b010, 32'h40000000, 32'h0);
        check("abort word intact", got_rdata, 32'h80FF7F01);

`ifdef MISALIGN_SPLIT_EN
        // Reset during ACC2 of a split store: first half lands, second must not.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40000006; req_wdata = 32'hAABBCCDD;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("split abort acc2 addr", dmem_addr, 32'h40000008);
        rstn = 1'b0;
        #1;
        check("split abort we gated", 32'(dmem_we), 32'd0);
        @(negedge clk);
        check("split abort idle", 32'(req_ready), 32'd1);
        check("split abort no resp", 32'(resp_valid), 32'd0);
        rstn = 1'b1;
        issue(1'b0, 3'b010, 32'h40000008, 32'h0);
        check("split abort word2 intact", got_rdata, 32'h00001155);
        issue(1'b0, 3'b010, 32'h40000004, 32'h0);
        check("split abort word1 written", got_rdata, 32'hCCDD8800);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
